// File: rtl/ble_cmd_sender.sv
// Host-side BLE command link: sends a 16-bit command as two 8N1 UART bytes,
// high byte first, then waits for the robot's one-byte acknowledge or a timeout.
module ble_cmd_sender #(
  parameter int BAUD_DIV = 5208,
  parameter int TMO_CYC  = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        tmo
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_e;

  tx_state_e       tx_state_q, tx_state_d;
  logic [BW-1:0]   tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [15:0]     cmd_q, cmd_d;
  logic            tx_q, tx_d;
  logic            cmd_snt_q, cmd_snt_d;
  logic            tmo_q, tmo_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      resp_q, resp_d;
  logic            resp_rdy_q, resp_rdy_d;
  logic [7:0]      tx_byte;
  logic            accept;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [BW-1:0]   rx_baud_q, rx_baud_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shift_q, rx_shift_d;
  logic            rx_done_q, rx_done_d;

  // Receiver: bit 0 is the start bit, 1..8 data (LSB first), 9 the stop bit.
  // The fall is seen one cycle after the synchronizer, so the half-bit count starts at 1.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_baud_d  = BW'(1);
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = 4'd1;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          if (rx_bit_q == 4'd9) begin
            rx_done_d  = rx_s2_q;
            rx_state_d = RX_IDLE;
          end else begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    cmd_d      = cmd_q;
    cmd_snt_d  = 1'b0;
    tmo_d      = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    accept     = 1'b0;
    case (tx_state_q)
      IDLE: begin
        if (snd_cmd) begin
          accept     = 1'b1;
          cmd_d      = cmd;
          tx_state_d = TX_HI;
          tx_baud_d  = '0;
          tx_bit_d   = 4'd0;
        end
      end
      TX_HI, TX_LO: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_bit_d = 4'd0;
            if (tx_state_q == TX_HI) begin
              tx_state_d = TX_LO;
            end else begin
              tx_state_d = WAIT_RESP;
              cmd_snt_d  = 1'b1;
              tmo_cnt_d  = '0;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + 1'b1;
        end
      end
      WAIT_RESP: begin
        // A completed byte beats a timeout expiring on the same edge.
        if (rx_done_q) begin
          tx_state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_d      = 1'b1;
          tx_state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // TX is registered from the next-state frame position so the line never glitches.
  always_comb begin
    tx_byte = (tx_state_d == TX_HI) ? cmd_d[15:8] : cmd_d[7:0];
    tx_d    = 1'b1;
    if (tx_state_d == TX_HI || tx_state_d == TX_LO) begin
      case (tx_bit_d)
        4'd0:    tx_d = 1'b0;
        4'd9:    tx_d = 1'b1;
        default: tx_d = tx_byte[3'(tx_bit_d - 4'd1)];
      endcase
    end
  end

  always_comb begin
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    if (clr_resp_rdy) resp_rdy_d = 1'b0;
    if (rx_done_q) begin
      resp_rdy_d = 1'b1;
      resp_d     = rx_shift_q;
    end
    if (accept) resp_rdy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= 4'd0;
      cmd_q      <= 16'h0000;
      tx_q       <= 1'b1;
      cmd_snt_q  <= 1'b0;
      tmo_q      <= 1'b0;
      tmo_cnt_q  <= '0;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_done_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      cmd_q      <= cmd_d;
      tx_q       <= tx_d;
      cmd_snt_q  <= cmd_snt_d;
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
      rx_s1_q    <= RX;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = (tx_state_q != IDLE);
  assign cmd_snt  = cmd_snt_q;
  assign tmo      = tmo_q;
  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_ble_cmd_sender.sv
// Self-checking bench for ble_cmd_sender: a cycle-timeline model derived from the
// frame/timeout arithmetic is compared against every output on every cycle.
module tb_ble_cmd_sender;

  localparam int B = 8;
  localparam int T = 1000;
  localparam int RX_LAT = 3 + B / 2 + 9 * B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX, busy, cmd_snt, resp_rdy, tmo;
  logic [7:0]  resp;

  ble_cmd_sender #(.BAUD_DIV(B), .TMO_CYC(T)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .snd_cmd(snd_cmd),
    .clr_resp_rdy(clr_resp_rdy), .RX(RX), .TX(TX), .busy(busy),
    .cmd_snt(cmd_snt), .resp(resp), .resp_rdy(resp_rdy), .tmo(tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [7:0] val;
  } rx_evt_t;

  int      cyc = 0;
  int      checks = 0;
  int      passed = 0;
  bit      cmp_en = 1'b0;
  rx_evt_t rxq[$];

  // Model: mode 0 idle, 1 sending (started at edge t0), 2 waiting (cmd_snt at edge c).
  int       m_mode = 0;
  int       m_t0 = 0;
  int       m_c = 0;
  logic     m_frame[20];
  logic     e_tx = 1'b1, e_busy = 1'b0, e_snt = 1'b0, e_tmo = 1'b0, e_rdy = 1'b0;
  logic [7:0] e_resp = 8'h00;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  // Model update at each rising edge: outputs for the interval following edge cyc.
  initial forever begin
    bit         byte_evt;
    bit         accept;
    logic [7:0] byte_val;
    @(posedge clk);
    cyc++;
    byte_evt = 1'b0;
    byte_val = 8'h00;
    accept   = 1'b0;
    if (rxq.size() > 0 && rxq[0].at == cyc) begin
      byte_evt = 1'b1;
      byte_val = rxq[0].val;
      void'(rxq.pop_front());
    end
    e_snt = 1'b0;
    e_tmo = 1'b0;
    if (rst) begin
      m_mode = 0;
      e_resp = 8'h00;
      e_rdy  = 1'b0;
      rxq.delete();
    end else begin
      case (m_mode)
        0: if (snd_cmd) begin
          accept = 1'b1;
          m_mode = 1;
          m_t0   = cyc;
          m_frame[0]  = 1'b0;
          m_frame[9]  = 1'b1;
          m_frame[10] = 1'b0;
          m_frame[19] = 1'b1;
          for (int i = 0; i < 8; i++) begin
            m_frame[1 + i]  = cmd[8 + i];
            m_frame[11 + i] = cmd[i];
          end
        end
        1: if (cyc == m_t0 + 20 * B) begin
          m_mode = 2;
          m_c    = cyc;
          e_snt  = 1'b1;
        end
        default: begin
          if (byte_evt) m_mode = 0;
          else if (cyc == m_c + T) begin
            e_tmo  = 1'b1;
            m_mode = 0;
          end
        end
      endcase
      if (clr_resp_rdy) e_rdy = 1'b0;
      if (byte_evt) begin
        e_rdy  = 1'b1;
        e_resp = byte_val;
      end
      if (accept) e_rdy = 1'b0;
    end
    e_busy = (m_mode != 0);
    e_tx   = (m_mode == 1) ? m_frame[(cyc - m_t0) / B] : 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      checkOutput("TX", 16'(TX), 16'(e_tx));
      checkOutput("busy", 16'(busy), 16'(e_busy));
      checkOutput("cmd_snt", 16'(cmd_snt), 16'(e_snt));
      checkOutput("tmo", 16'(tmo), 16'(e_tmo));
      checkOutput("resp_rdy", 16'(resp_rdy), 16'(e_rdy));
      checkOutput("resp", 16'(resp), 16'(e_resp));
    end
  end

  task automatic waitUntil(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait_busy", 16'(busy), 16'h0);
  endtask

  task automatic applyStimulus(input logic [15:0] cmd_v, output int acc);
    @(posedge clk);
    #1;
    cmd     = cmd_v;
    snd_cmd = 1'b1;
    @(posedge clk);
    #1;
    acc     = cyc;
    snd_cmd = 1'b0;
  endtask

  // Drives one 8N1 frame on RX; side 1 pulses clr_resp_rdy, side 2 pulses snd_cmd,
  // both on the edge where the byte lands.
  task automatic rxByte(input logic [7:0] val, input bit stop_ok, input int side, output int p);
    logic    f[10];
    rx_evt_t ev;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = val[i];
    f[9] = stop_ok;
    @(posedge clk);
    #1;
    p = cyc;
    if (stop_ok) begin
      ev.at  = p + RX_LAT;
      ev.val = val;
      rxq.push_back(ev);
    end
    for (int t = 0; t < 10 * B; t++) begin
      RX = f[t / B];
      if (side == 1) clr_resp_rdy = (t == RX_LAT - 1);
      if (side == 2) begin
        snd_cmd = (t == RX_LAT - 1);
        if (t == RX_LAT - 1) cmd = 16'($urandom);
      end
      @(posedge clk);
      #1;
    end
    RX = 1'b1;
    clr_resp_rdy = 1'b0;
    snd_cmd = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         acc, p, sel;
    logic       lit_bits [0:19];
    logic [19:0] lit_vec;
    logic       got[20];
    logic [7:0] hi, lo;

    // Reset values
    waitUntil(3);
    checkOutput("reset_TX", 16'(TX), 16'h1);
    checkOutput("reset_busy", 16'(busy), 16'h0);
    checkOutput("reset_cmd_snt", 16'(cmd_snt), 16'h0);
    checkOutput("reset_resp", 16'(resp), 16'h00);
    checkOutput("reset_resp_rdy", 16'(resp_rdy), 16'h0);
    checkOutput("reset_tmo", 16'(tmo), 16'h0);
    cmp_en = 1'b1;
    rst = 1'b0;

    // Basic send of 0x3C5A against the literal bit stream
    lit_vec = 20'b0001111001_0010110101;
    for (int k = 0; k < 20; k++) lit_bits[k] = lit_vec[19 - k];
    applyStimulus(16'h3C5A, acc);
    for (int k = 0; k < 20; k++) begin
      waitUntil(acc + k * B + B / 2);
      checkOutput($sformatf("basic_tx_bit%0d", k), 16'(TX), 16'(lit_bits[k]));
    end
    waitUntil(acc + 159);
    checkOutput("basic_cmd_snt_early", 16'(cmd_snt), 16'h0);
    waitUntil(acc + 160);
    checkOutput("basic_cmd_snt", 16'(cmd_snt), 16'h1);
    checkOutput("basic_busy", 16'(busy), 16'h1);

    // Acknowledge
    rxByte(8'hA5, 1'b1, 0, p);
    checkOutput("ack_resp", 16'(resp), 16'h00A5);
    checkOutput("ack_resp_rdy", 16'(resp_rdy), 16'h1);
    checkOutput("ack_busy", 16'(busy), 16'h0);
    @(negedge clk);
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    checkOutput("clr_resp_rdy", 16'(resp_rdy), 16'h0);

    // Timeout
    applyStimulus(16'h0000, acc);
    waitUntil(acc + 160 + T - 1);
    checkOutput("tmo_early", 16'(tmo), 16'h0);
    checkOutput("tmo_busy_early", 16'(busy), 16'h1);
    waitUntil(acc + 160 + T);
    checkOutput("tmo_pulse", 16'(tmo), 16'h1);
    checkOutput("tmo_busy", 16'(busy), 16'h0);
    checkOutput("tmo_resp_rdy", 16'(resp_rdy), 16'h0);
    waitUntil(acc + 160 + T + 1);
    checkOutput("tmo_single", 16'(tmo), 16'h0);

    // Busy rejection: 0xFFFF requested during the low byte of 0x1234
    applyStimulus(16'h1234, acc);
    for (int k = 0; k < 20; k++) begin
      waitUntil(acc + k * B + B / 2);
      got[k] = TX;
      if (k == 12) begin
        cmd = 16'hFFFF;
        snd_cmd = 1'b1;
      end
      if (k == 13) snd_cmd = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      hi[i] = got[1 + i];
      lo[i] = got[11 + i];
    end
    checkOutput("reject_hi_byte", 16'(hi), 16'h0012);
    checkOutput("reject_lo_byte", 16'(lo), 16'h0034);
    waitIdle();
    waitUntil(cyc + 200);
    checkOutput("reject_no_resend", 16'(busy), 16'h0);

    // Receiver robustness
    @(posedge clk);
    #1;
    RX = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    RX = 1'b1;
    waitUntil(cyc + 100);
    checkOutput("glitch_resp_rdy", 16'(resp_rdy), 16'h0);
    rxByte(8'h5A, 1'b0, 0, p);
    waitUntil(cyc + 20);
    checkOutput("framing_resp_rdy", 16'(resp_rdy), 16'h0);
    checkOutput("framing_resp", 16'(resp), 16'h00A5);
    rxByte(8'h3C, 1'b1, 1, p);
    checkOutput("set_beats_clr", 16'(resp_rdy), 16'h1);
    checkOutput("set_clr_resp", 16'(resp), 16'h003C);
    rxByte(8'hC3, 1'b1, 2, p);
    waitUntil(p + RX_LAT + 1);
    checkOutput("accept_clears_rdy", 16'(resp_rdy), 16'h0);
    checkOutput("accept_resp", 16'(resp), 16'h00C3);
    checkOutput("accept_busy", 16'(busy), 16'h1);
    waitIdle();

    // Reset in the middle of a send
    applyStimulus(16'($urandom), acc);
    waitUntil(acc + 49);
    rst = 1'b1;
    waitUntil(acc + 50);
    rst = 1'b0;
    checkOutput("midrst_TX", 16'(TX), 16'h1);
    checkOutput("midrst_busy", 16'(busy), 16'h0);
    checkOutput("midrst_resp", 16'(resp), 16'h00);
    checkOutput("midrst_resp_rdy", 16'(resp_rdy), 16'h0);
    checkOutput("midrst_cmd_snt", 16'(cmd_snt), 16'h0);
    checkOutput("midrst_tmo", 16'(tmo), 16'h0);
    applyStimulus(16'h8E71, acc);
    waitUntil(acc + 160);
    checkOutput("after_rst_cmd_snt", 16'(cmd_snt), 16'h1);
    rxByte(8'hA5, 1'b1, 0, p);
    checkOutput("after_rst_ack", 16'(resp), 16'h00A5);

    // Randomized sends, acknowledges, bad frames and rejected requests
    for (int it = 0; it < 6; it++) begin
      waitIdle();
      applyStimulus(16'($urandom), acc);
      if ($urandom_range(1) == 1) begin
        waitUntil(acc + $urandom_range(10, 150));
        cmd = 16'($urandom);
        snd_cmd = 1'b1;
        @(negedge clk);
        snd_cmd = 1'b0;
      end
      waitUntil(acc + 160 + $urandom_range(0, 200));
      sel = $urandom_range(2);
      if (sel == 1) rxByte(8'($urandom), 1'b1, 0, p);
      else if (sel == 2) rxByte(8'($urandom), 1'b0, 0, p);
      waitIdle();
    end

    waitUntil(cyc + 20);
    checkOutput("rx_queue_drained", 16'(rxq.size()), 16'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ble_cmd_sender.md
# ble_cmd_sender

Remote end of the maze runner's Bluetooth command link. The block serializes a 16-bit command as two 8N1 UART bytes, high byte first, on `TX`. It then waits for the one-byte acknowledge (0xA5) that the robot returns on `RX`. It is used as the host/BLE-side master in full-chip benches and in the handheld controller FPGA.

## Interface
**Parameters**
- `BAUD_DIV`, default 5208: clocks per UART bit (50 MHz / 9600 baud). Minimum 4.
- `TMO_CYC`, default 25000000: maximum clocks spent in `WAIT_RESP` before giving up (0.5 s).

**Ports**
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd`  in  16  command to send; captured when `snd_cmd` is accepted.
- `snd_cmd`  in  1  request to send `cmd`; accepted only in `IDLE`.
- `clr_resp_rdy`  in  1  clears `resp_rdy`.
- `RX`  in  1  UART from the robot; asynchronous, double-flopped internally.
- `TX`  out  1  UART to the robot; idles high.
- `busy`  out  1  high in any state other than `IDLE`.
- `cmd_snt`  out  1  one-cycle pulse when the low byte's stop bit completes.
- `resp`  out  8  last correctly framed byte received.
- `resp_rdy`  out  1  set when a new byte is loaded into `resp`; held until cleared.
- `tmo`  out  1  one-cycle pulse when the response timeout expires.

## Operation
**Transmit FSM.** States are `IDLE`, `TX_HI`, `TX_LO` and `WAIT_RESP`.
- `IDLE`: when `snd_cmd`=1, capture `cmd` into the shift register, clear `resp_rdy`, and go to `TX_HI`. A `snd_cmd` in any other state is ignored and does not touch the latched command.
- `TX_HI` / `TX_LO`: send `cmd[15:8]` then `cmd[7:0]`. Each frame is a start bit (0), 8 data bits LSB first, and a stop bit (1). Each bit lasts exactly `BAUD_DIV` clocks. There is no idle gap between the two frames.
- After the low-byte stop bit: pulse `cmd_snt`, clear the timeout counter, and go to `WAIT_RESP`.
- `WAIT_RESP`: a correctly framed received byte returns the FSM to `IDLE`. If the counter reaches `TMO_CYC-1`, pulse `tmo` and return to `IDLE`.
- The response value is not checked. The consumer compares `resp` against 0xA5.

**Receiver.** The receiver runs continuously, independent of the FSM.
- Idle: a falling edge on the synchronized `RX` starts a frame.
- At `BAUD_DIV/2` clocks (integer divide) the start bit is re-sampled. If it is high, this is a false start: return to idle with no output.
- Each data bit is then sampled every `BAUD_DIV` clocks at mid-bit, LSB first, followed by the stop bit.
- Stop bit = 1: load `resp` and set `resp_rdy`.
- Stop bit = 0 (framing error): discard the byte; `resp` and `resp_rdy` are unchanged.
- A byte received outside `WAIT_RESP` still updates `resp` and `resp_rdy` but does not affect the FSM.

**Arithmetic and widths.**
- Baud counter: `$clog2(BAUD_DIV)` bits.
- Bit counter: 4 bits, range 0–9.
- Timeout counter: `$clog2(TMO_CYC)` bits. It runs only in `WAIT_RESP` and never wraps.

**Simultaneous events.**
- Set and `clr_resp_rdy` in the same cycle: set wins.
- `snd_cmd` accepted and a byte completing in the same cycle: `resp_rdy` ends up 0 and `resp` is updated.
- Response arriving in the same cycle the timeout expires: the response wins and `tmo` does not pulse.

**Reset.** `rst` takes effect at the next edge even mid-frame: FSM to `IDLE`, receiver to idle, and all counters cleared.

## Timing
- Reset values: `TX`=1, `busy`=0, `cmd_snt`=0, `resp`=0x00, `resp_rdy`=0, `tmo`=0, both synchronizer flops = 1.
- `snd_cmd` is sampled high at edge N:
  - `busy`=1 and `TX`=0 from cycle N+1.
  - The high-byte start bit occupies cycles N+1 .. N+`BAUD_DIV`.
  - Bit k of the stream (0 = high start, 19 = low stop) occupies cycles N+1+k·`BAUD_DIV` .. N+(k+1)·`BAUD_DIV`.
  - `cmd_snt`=1 in cycle N+20·`BAUD_DIV`+1 only. `TX` stays 1 from then on.
- `RX` falling edge at the pin: recognized 2 clocks later (synchronizer).
  - Stop-bit sample occurs at 2 + `BAUD_DIV/2` + 9·`BAUD_DIV` clocks after that edge.
  - `resp_rdy` and `resp` update on the following edge.
  - `busy` drops on that same edge when the FSM is in `WAIT_RESP`.
- `tmo` pulses `TMO_CYC` cycles after `cmd_snt`. `busy` falls together with the `tmo` pulse.
- Earliest next `snd_cmd` acceptance is the first cycle with `busy`=0.

## Test plan
- **Basic send** (`BAUD_DIV`=8, `TMO_CYC`=1000): `cmd`=0x3C5A, pulse `snd_cmd` → `TX` carries 0,0,0,1,1,1,1,0,0,1 then 0,0,1,0,1,1,0,1,0,1, 8 clocks per bit. `cmd_snt` fires 160 cycles after acceptance and `busy` stays 1.
- **Acknowledge**: after the basic send, drive 0xA5 on `RX` with 8-clock bits → `resp`=0xA5 and `resp_rdy`=1, `busy`=0 on the same edge. `clr_resp_rdy` then returns `resp_rdy` to 0.
- **Timeout**: send 0x0000 with no `RX` activity → exactly one `tmo` pulse 1000 cycles after `cmd_snt`, `busy`=0, `resp_rdy`=0.
- **Busy rejection**: pulse `snd_cmd` with 0xFFFF during `TX_LO` of a 0x1234 send → the wire carries only 0x12 then 0x34, and no second transmission follows.
- **Receiver robustness**: a 3-clock low glitch on `RX` → no `resp_rdy`. A frame 0x5A with its stop bit forced to 0 → no `resp_rdy`, `resp` unchanged. Set and `clr_resp_rdy` in the same cycle → `resp_rdy`=1.
- **Reset mid-frame**: assert `rst` for one cycle at cycle 50 of a send → next cycle `TX`=1, `busy`=0, all outputs at reset values. A new `snd_cmd` then transmits normally.
